// File: rtl/e203_exu_ordwbck_agemx.sv
// ---------------------------------------------------------------------------
// e203_exu_ordwbck_agemx
// Age matrix for the write-back buffer. It records relative age between
// occupied entries and picks the oldest entry of a request vector.
//   age bit (i,j) set  => entry i is older than entry j.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   vld         : current (registered) entry valid vector
//   alloc_oh    : one-hot entry being allocated this cycle (or zero)
//   free_oh     : one-hot entry being released this cycle (or zero)
//   req         : request vector to pick the oldest from
//   oldest      : one-hot oldest requesting entry (zero if req is zero)
// ---------------------------------------------------------------------------
module e203_exu_ordwbck_agemx #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] vld,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] free_oh,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] oldest
);

    // Flattened matrix: bit (i*DEPTH + j) holds age(i,j).
    logic [DEPTH*DEPTH-1:0] age_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    // Free wins: a released entry's row and column are wiped,
                    // even if another entry is allocated in the same cycle.
                    if (free_oh[i] || free_oh[j]) begin
                        age_reg[i*DEPTH+j] <= 1'b0;
                    end else if (alloc_oh[j]) begin
                        // Every entry already resident is older than the new one.
                        age_reg[i*DEPTH+j] <= vld[i] && (i != j);
                    end else if (alloc_oh[i]) begin
                        // New entry is older than nobody.
                        age_reg[i*DEPTH+j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Entry gi is oldest if no other requester is older than it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pick
            logic [DEPTH-1:0] older_col;
            always_comb begin
                older_col = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    older_col[j] = age_reg[j*DEPTH+gi];
                end
            end
            assign oldest[gi] = req[gi] & ~(|(req & older_col));
        end
    endgenerate

endmodule

// File: rtl/e203_exu_ordwbck.sv
// ---------------------------------------------------------------------------
// e203_exu_ordwbck
// Buffered in-order write-back arbiter. Results from CH_NUM execution
// channels are accepted one per cycle (round-robin), held in a DEPTH-entry
// buffer and drained onto one regfile write-back port. Long-pipe results
// leave only when their itag matches the OITF head (and retire it); short
// results leave oldest-first.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid/in_ready               : per-channel result handshake
//   in_wdat/in_rdidx/in_itag        : per-channel packed result fields
//   in_longp/in_rdwen               : per-channel long-pipe / write-enable flags
//   oitf_empty/oitf_ret_ptr         : OITF state (head itag)
//   oitf_ret_ena                    : retire OITF head this cycle
//   wbck_o_*                        : regfile write-back port
//   buf_cnt/buf_empty               : buffer occupancy
// ---------------------------------------------------------------------------
// Width macros normally come from e203_defines.v; defaults allow standalone use.
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_ITAG_WIDTH
`define E203_ITAG_WIDTH 2
`endif

module e203_exu_ordwbck #(
    parameter int CH_NUM  = 2,
    parameter int DEPTH   = 4,
    parameter int XLEN    = `E203_XLEN,
    parameter int RFIDX_W = `E203_RFIDX_WIDTH,
    parameter int ITAG_W  = `E203_ITAG_WIDTH,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CH_NUM-1:0]           in_valid,
    output logic [CH_NUM-1:0]           in_ready,
    input  logic [CH_NUM*XLEN-1:0]      in_wdat,
    input  logic [CH_NUM*RFIDX_W-1:0]   in_rdidx,
    input  logic [CH_NUM*ITAG_W-1:0]    in_itag,
    input  logic [CH_NUM-1:0]           in_longp,
    input  logic [CH_NUM-1:0]           in_rdwen,
    input  logic                        oitf_empty,
    input  logic [ITAG_W-1:0]           oitf_ret_ptr,
    output logic                        oitf_ret_ena,
    output logic                        wbck_o_valid,
    input  logic                        wbck_o_ready,
    output logic [XLEN-1:0]             wbck_o_wdat,
    output logic [RFIDX_W-1:0]          wbck_o_rdidx,
    output logic                        wbck_o_rdwen,
    output logic [CNT_W-1:0]            buf_cnt,
    output logic                        buf_empty
);

    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int IDX_W = $clog2(DEPTH);

    // Entry storage: valid bits are reset, payload is don't-care until valid.
    logic [DEPTH-1:0]   vld_reg;
    logic [DEPTH-1:0]   longp_reg;
    logic [DEPTH-1:0]   rdwen_reg;
    logic [XLEN-1:0]    wdat_reg  [DEPTH];
    logic [RFIDX_W-1:0] rdidx_reg [DEPTH];
    logic [ITAG_W-1:0]  itag_reg  [DEPTH];

    logic [CNT_W-1:0]   cnt_reg;
    logic [CH_W-1:0]    rr_ptr_reg;
    logic               lock_reg;
    logic [IDX_W-1:0]   lock_idx_reg;

    // ---------------- intake arbitration ----------------
    logic [CH_NUM-1:0]  grant;
    logic [CH_W-1:0]    gidx;
    logic               found;
    logic               drop;
    logic               full;
    logic               accept;
    logic               alloc;

    always_comb begin
        int c;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            c = int'(rr_ptr_reg) + k;
            if (c >= CH_NUM) c = c - CH_NUM;
            if (!found && in_valid[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                gidx     = CH_W'(c);
            end
        end
    end

    // Fullness looks only at the registered count, so a release in the
    // current cycle never opens the input port combinationally.
    assign full   = (cnt_reg == CNT_W'(DEPTH));
    // Short results that write nothing are consumed without taking an entry.
    assign drop   = found & ~in_longp[gidx] & ~in_rdwen[gidx];
    assign in_ready = grant & {CH_NUM{drop | ~full}};
    assign accept = found & (drop | ~full);
    assign alloc  = accept & ~drop;

    // Lowest-index free entry (based on registered valid bits, so an entry
    // released this cycle is not reused until the next one).
    logic [DEPTH-1:0] alloc_oh;
    logic [IDX_W-1:0] alloc_idx;
    always_comb begin
        alloc_oh  = '0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_reg[i]) begin
                alloc_oh  = '0;
                alloc_oh[i] = alloc;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // ---------------- eligibility and selection ----------------
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] short_oldest;
    logic [DEPTH-1:0] free_oh;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;
    logic             rel;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
            assign elig[gi] = vld_reg[gi] &
                (~longp_reg[gi] | (~oitf_empty & (itag_reg[gi] == oitf_ret_ptr)));
        end
    endgenerate

    e203_exu_ordwbck_agemx #(
        .DEPTH (DEPTH)
    ) u_agemx (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld_reg),
        .alloc_oh (alloc_oh),
        .free_oh  (free_oh),
        .req      (elig & ~longp_reg),
        .oldest   (short_oldest)
    );

    // An eligible long-pipe entry (at most one can match the OITF head)
    // takes priority over any short entry.
    always_comb begin
        logic long_hit;
        long_hit = 1'b0;
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i] && longp_reg[i]) begin
                long_hit = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
        if (long_hit) begin
            pick_any = 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (short_oldest[i]) begin
                    pick_any = 1'b1;
                    pick_idx = IDX_W'(i);
                end
            end
        end
    end

    // While a presented result is stalled, the choice is frozen so the
    // output cannot change under a pending request.
    assign sel_vld = lock_reg | pick_any;
    assign sel_idx = lock_reg ? lock_idx_reg : pick_idx;
    assign rel     = sel_vld & wbck_o_ready;

    always_comb begin
        free_oh = '0;
        free_oh[sel_idx] = rel;
    end

    assign wbck_o_valid = sel_vld;
    assign wbck_o_wdat  = sel_vld ? wdat_reg[sel_idx]  : '0;
    assign wbck_o_rdidx = sel_vld ? rdidx_reg[sel_idx] : '0;
    assign wbck_o_rdwen = sel_vld & rdwen_reg[sel_idx];
    assign oitf_ret_ena = rel & longp_reg[sel_idx];
    assign buf_cnt      = cnt_reg;
    assign buf_empty    = (cnt_reg == '0);

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg      <= '0;
            cnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            vld_reg <= (vld_reg & ~free_oh) | alloc_oh;
            if (alloc && !rel) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (!alloc && rel) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (accept) begin
                rr_ptr_reg <= (gidx == CH_W'(CH_NUM - 1)) ? '0 : gidx + CH_W'(1);
            end
            if (rel) begin
                lock_reg <= 1'b0;
            end else if (sel_vld) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= sel_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            wdat_reg[alloc_idx]  <= in_wdat[int'(gidx)*XLEN +: XLEN];
            rdidx_reg[alloc_idx] <= in_rdidx[int'(gidx)*RFIDX_W +: RFIDX_W];
            itag_reg[alloc_idx]  <= in_itag[int'(gidx)*ITAG_W +: ITAG_W];
            longp_reg[alloc_idx] <= in_longp[gidx];
            rdwen_reg[alloc_idx] <= in_rdwen[gidx];
        end
    end

endmodule
